// File: rtl/bcd_pkg.sv
// Shared BCD definitions: converter state encoding and digit constants,
// used by both the bcd2bin and bin2bcd sides of the display path.
package bcd_pkg;

    localparam int         DIGIT_W    = 4;
    localparam logic [3:0] DIGIT_MAX  = 4'd9;
    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_SUB    = 4'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        SHIFT  = 3'd2,
        ADJUST = 3'd3,
        FINISH = 3'd4
    } state_t;

    function automatic logic digit_valid(input logic [3:0] d);
        return d <= DIGIT_MAX;
    endfunction

endpackage

// File: rtl/bcd2bin_if.sv
// Start/done handshake bundle between a BCD source and the bcd2bin converter.
interface bcd2bin_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
);
    logic [4*DIGITS-1:0] bcd_in;
    logic                start;
    logic [BIN_W-1:0]    bin;
    logic                err;
    logic                busy;
    logic                done;

    modport master (output bcd_in, start, input bin, err, busy, done);
    modport slave  (input bcd_in, start, output bin, err, busy, done);
endinterface

// File: rtl/bcd_digit_adj.sv
// One-digit step of reverse double-dabble: digits >= 8 lose 3 after a right
// shift; also reports whether the digit is a legal BCD value.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       valid
);

    assign q     = (d >= ADJ_THRESH) ? (d - ADJ_SUB) : d;
    assign valid = digit_valid(d);

endmodule

// File: rtl/bcd2bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble) with a level
// start/done handshake and a non-BCD digit error flag.
//
// state  | meaning
// IDLE   | waiting for start, or for start to drop after done
// CHECK  | scan latched digits for nibbles > 9
// SHIFT  | shift one bit from the digit register into the accumulator
// ADJUST | subtract 3 from every digit >= 8
// FINISH | publish result or error, raise done
module bcd2bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic         clk,
    input  logic         nrst,
    bcd2bin_if.slave     bus
);

    localparam int              BCD_W    = DIGIT_W * DIGITS;
    localparam int              CNT_W    = $clog2(BIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [BCD_W-1:0]   digit_reg;
    logic [BCD_W-1:0]   adj_word;
    logic [DIGITS-1:0]  digit_ok;
    logic [BIN_W-1:0]   acc;
    logic [BIN_W-1:0]   bin_q;
    logic               err_q;
    logic               busy_q;
    logic               done_q;
    logic               bad;
    logic               all_valid;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d     (digit_reg[g*DIGIT_W +: DIGIT_W]),
            .q     (adj_word[g*DIGIT_W +: DIGIT_W]),
            .valid (digit_ok[g])
        );
    end

    assign all_valid = &digit_ok;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            cnt       <= '0;
            digit_reg <= '0;
            acc       <= '0;
            bin_q     <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bad       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && !done_q) begin
                        digit_reg <= bus.bcd_in;
                        acc       <= '0;
                        cnt       <= '0;
                        bad       <= 1'b0;
                        busy_q    <= 1'b1;
                        state     <= CHECK;
                    end else if (!bus.start && done_q) begin
                        done_q <= 1'b0;
                    end
                end
                CHECK: begin
                    if (!all_valid) begin
                        bad   <= 1'b1;
                        state <= FINISH;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc       <= {digit_reg[0], acc[BIN_W-1:1]};
                    digit_reg <= digit_reg >> 1;
                    if (cnt == CNT_LAST) begin
                        state <= FINISH;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        state <= ADJUST;
                    end
                end
                ADJUST: begin
                    digit_reg <= adj_word;
                    state     <= SHIFT;
                end
                FINISH: begin
                    if (bad) begin
                        bin_q <= '0;
                        err_q <= 1'b1;
                    end else begin
                        bin_q <= acc;
                        err_q <= 1'b0;
                    end
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.bin  = bin_q;
    assign bus.err  = err_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_bcd2bin.sv
// Self-checking bench for bcd2bin: directed and random conversions against an
// arithmetic BCD model, handshake/latency checks, reset abort, 2-digit round trip.
module tb_bcd2bin;

    logic clk;
    logic nrst;
    int   total;
    int   bad;

    bcd2bin_if #(.DIGITS(3), .BIN_W(10)) if1 ();
    bcd2bin_if #(.DIGITS(2), .BIN_W(7))  if2 ();

    bcd2bin #(.DIGITS(3), .BIN_W(10)) u_dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (if1)
    );

    bcd2bin #(.DIGITS(2), .BIN_W(7)) u_dut2 (
        .clk  (clk),
        .nrst (nrst),
        .bus  (if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decimal value of a packed BCD word; e=1 if any digit is above 9.
    function automatic int unsigned ref_val(input logic [31:0] b, input int digits, output bit e);
        int unsigned v = 0;
        int unsigned w = 1;
        e = 1'b0;
        for (int i = 0; i < digits; i++) begin
            int unsigned nib = (b >> (4 * i)) & 32'hF;
            if (nib > 9) e = 1'b1;
            v += nib * w;
            w *= 10;
        end
        return e ? 0 : v;
    endfunction

    task automatic run1(input logic [11:0] b, input bit mid_change, input string tag);
        bit          e;
        int unsigned exp_v;
        int          cyc;
        int          exp_lat;
        exp_v   = ref_val({20'd0, b}, 3, e);
        exp_lat = e ? 3 : 22;
        if1.bcd_in = b;
        if1.start  = 1'b1;
        cyc = 0;
        while (cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                chk({tag, "_busy_on"}, {31'd0, if1.busy}, 32'd1);
                if (mid_change) if1.bcd_in = ~b;
            end
            if (if1.done) break;
        end
        chk({tag, "_latency"}, cyc, exp_lat);
        chk({tag, "_bin"}, {22'd0, if1.bin}, exp_v);
        chk({tag, "_err"}, {31'd0, if1.err}, {31'd0, e});
        chk({tag, "_busy_off"}, {31'd0, if1.busy}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_hold"}, {30'd0, if1.done, if1.busy}, 32'd2);
        if1.start = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_clear"}, {31'd0, if1.done}, 32'd0);
    endtask

    task automatic run2(input int v);
        int cyc;
        if2.bcd_in = {4'(v / 10), 4'(v % 10)};
        if2.start  = 1'b1;
        cyc = 0;
        while (cyc < 30 && !if2.done) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk($sformatf("rt%0d_lat", v), cyc, 16);
        chk($sformatf("rt%0d_bin", v), {25'd0, if2.bin}, v);
        chk($sformatf("rt%0d_err", v), {31'd0, if2.err}, 32'd0);
        if2.start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [11:0] rb;
        int          cyc;
        total = 0;
        bad   = 0;
        nrst  = 1'b0;
        if1.start = 1'b0; if1.bcd_in = '0;
        if2.start = 1'b0; if2.bcd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {if1.bin, if1.err, if1.busy, if1.done}, 32'd0);
        nrst = 1'b1;
        @(posedge clk); #1;

        run1(12'h999, 1'b0, "c999");
        run1(12'h000, 1'b0, "c000");
        run1(12'h255, 1'b0, "c255");
        run1(12'h100, 1'b0, "c100");
        run1(12'h1A3, 1'b0, "c1A3");
        run1(12'h042, 1'b0, "c042");
        run1(12'h567, 1'b1, "cmid");
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < 3; i++) rb[4*i +: 4] = 4'($urandom_range(0, 11));
            run1(rb, 1'b0, $sformatf("rnd%0d", n));
        end

        run1(12'h318, 1'b0, "pre_rst");
        if1.bcd_in = 12'h777;
        if1.start  = 1'b1;
        cyc = 0;
        while (cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
        end
        nrst = 1'b0;
        #1;
        chk("rst_mid", {if1.bin, if1.err, if1.busy, if1.done}, 32'd0);
        if1.start = 1'b0;
        #1;
        nrst = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        chk("rst_no_done", {if1.bin, if1.err, if1.busy, if1.done}, 32'd0);
        run1(12'h864, 1'b0, "post_rst");

        for (int v = 0; v < 100; v++) run2(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
